multicycle_control_fsm: RTL and testbench

Multicycle sequencer for the MIPS-subset datapath. It replaces the single-cycle decode with a Moore state machine that drives the shared ALU, unified memory port, instruction register and register file over 3-5 states per instruction. Memory accesses use a ready handshake so the block tolerates wait-state memories. It sits between the instruction register opcode field and all datapath mux/write-enable controls.

---
 rtl/multicycle_control_fsm_if.sv | 36 +++
 rtl/multicycle_control_fsm.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer (master) and the datapath (slave).
interface multicycle_control_fsm_if #(parameter int STATE_W = 4);
  logic [5:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_source;
  logic               instr_done;
  logic               illegal_op;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, state_dbg
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multicycle MIPS-subset datapath with wait-state memory handshake.
// Define ADDI_EN to decode ADDI (opcode 001000); otherwise it is reported as illegal.
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEM_ADDR = STATE_W'(2),
    MEM_RD   = STATE_W'(3),
    MEM_WB   = STATE_W'(4),
    MEM_WR   = STATE_W'(5),
    EXEC     = STATE_W'(6),
    R_WB     = STATE_W'(7),
    BRANCH   = STATE_W'(8),
    JUMP     = STATE_W'(9),
    ADDI_EX  = STATE_W'(10),
    ADDI_WB  = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
`ifdef ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  // fetch/done_on_ready/decode mark the few outputs that also depend on live inputs
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       fetch;
    logic       done;
    logic       done_on_ready;
    logic       decode;
  } ctl_t;

  state_t state;
  ctl_t   ctl_q;
  logic   run;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef ADDI_EN
      OP_ADDI:                          op_legal = 1'b1;
`endif
      default:                          op_legal = 1'b0;
    endcase
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op, input logic rdy);
    state_t ns;
    ns = FETCH;
    case (s)
      FETCH:    ns = rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_R:          ns = EXEC;
          OP_LW, OP_SW:  ns = MEM_ADDR;
          OP_BEQ:        ns = BRANCH;
          OP_J:          ns = JUMP;
`ifdef ADDI_EN
          OP_ADDI:       ns = ADDI_EX;
`endif
          default:       ns = FETCH;
        endcase
      end
      MEM_ADDR: ns = (op == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   ns = rdy ? MEM_WB : MEM_RD;
      MEM_WR:   ns = rdy ? FETCH : MEM_WR;
      EXEC:     ns = R_WB;
`ifdef ADDI_EN
      ADDI_EX:  ns = ADDI_WB;
`endif
      default:  ns = FETCH;
    endcase
    return ns;
  endfunction

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.fetch     = 1'b1;
      end
      DECODE: begin
        c.alu_src_b = 2'b11;
        c.decode    = 1'b1;
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.done       = 1'b1;
      end
      MEM_WR: begin
        c.mem_write     = 1'b1;
        c.i_or_d        = 1'b1;
        c.done_on_ready = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.done      = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.done          = 1'b1;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        c.done      = 1'b1;
      end
`ifdef ADDI_EN
      ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ADDI_WB: begin
        c.reg_write = 1'b1;
        c.done      = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  // Output decode is registered alongside the state so ctl_q always matches state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      ctl_q <= decode(FETCH);
    end else begin
      state <= next_state(state, bus.opcode, bus.mem_ready);
      ctl_q <= decode(next_state(state, bus.opcode, bus.mem_ready));
    end
  end

  // Reset blanks every output in the same cycle, including mid-wait
  assign run = ~rst;

  assign bus.pc_write      = run & (ctl_q.pc_write | (ctl_q.fetch & bus.mem_ready));
  assign bus.ir_write      = run & ctl_q.fetch & bus.mem_ready;
  assign bus.pc_write_cond = run & ctl_q.pc_write_cond;
  assign bus.i_or_d        = run & ctl_q.i_or_d;
  assign bus.mem_read      = run & ctl_q.mem_read;
  assign bus.mem_write     = run & ctl_q.mem_write;
  assign bus.mem_to_reg    = run & ctl_q.mem_to_reg;
  assign bus.reg_dst       = run & ctl_q.reg_dst;
  assign bus.reg_write     = run & ctl_q.reg_write;
  assign bus.alu_src_a     = run & ctl_q.alu_src_a;
  assign bus.alu_src_b     = {2{run}} & ctl_q.alu_src_b;
  assign bus.alu_op        = {2{run}} & ctl_q.alu_op;
  assign bus.pc_source     = {2{run}} & ctl_q.pc_source;
  assign bus.instr_done    = run & (ctl_q.done | (ctl_q.done_on_ready & bus.mem_ready));
  assign bus.illegal_op    = run & ctl_q.decode & ~op_legal(bus.opcode);
  assign bus.state_dbg     = run ? state : '0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: vector table, reset corner cases, random instruction stream vs trace model.
module tb_multicycle_control_fsm;
  localparam int STATE_W = 4;
`ifdef ADDI_EN
  localparam bit ADDI = 1'b1;
`else
  localparam bit ADDI = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  multicycle_control_fsm_if #(.STATE_W(STATE_W)) bus ();
  multicycle_control_fsm #(.STATE_W(STATE_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
  } ctl_s;

  typedef struct { int st; bit mr; logic [5:0] op; } cyc_t;

  // seq holds the expected state per cycle, nibble i = cycle i (read right to left)
  typedef struct {
    logic [5:0]  op;
    int          len;
    logic [31:0] seq;
    int          n_done, n_ill, n_rw, n_wr;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  cyc_t trace[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) ||
           (op == 6'd2) || (ADDI && op == 6'd8);
  endfunction

  // Control word each state must present, straight from the state table
  function automatic ctl_s exp_ctl(input int st, input bit mr, input logic [5:0] op);
    ctl_s c;
    c = '0;
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.pc_write = mr; c.ir_write = mr; end
      1:  begin c.alu_src_b = 2'b11; c.illegal_op = !legal(op); end
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.i_or_d = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      5:  begin c.mem_write = 1; c.i_or_d = 1; c.instr_done = mr; end
      6:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
      8:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; c.instr_done = 1; end
      9:  begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
      10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      11: begin c.reg_write = 1; c.instr_done = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_s sample();
    ctl_s a;
    a.pc_write = bus.pc_write;       a.pc_write_cond = bus.pc_write_cond;
    a.i_or_d = bus.i_or_d;           a.mem_read = bus.mem_read;
    a.mem_write = bus.mem_write;     a.ir_write = bus.ir_write;
    a.mem_to_reg = bus.mem_to_reg;   a.reg_dst = bus.reg_dst;
    a.reg_write = bus.reg_write;     a.alu_src_a = bus.alu_src_a;
    a.alu_src_b = bus.alu_src_b;     a.alu_op = bus.alu_op;
    a.pc_source = bus.pc_source;     a.instr_done = bus.instr_done;
    a.illegal_op = bus.illegal_op;
    return a;
  endfunction

  task automatic run_cycle(input int st, input bit mr, input logic [5:0] op, input string tag);
    bus.mem_ready = mr;
    bus.opcode    = op;
    bus.zero      = 1'($urandom);
    @(negedge clk);
    chk($sformatf("%s st%0d state", tag, st), 32'(bus.state_dbg), 32'(st));
    chk($sformatf("%s st%0d ctl", tag, st), 32'(sample()), 32'(exp_ctl(st, mr, op)));
    @(posedge clk); #1;
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = 1'b1;
      bus.opcode    = 6'($urandom);
      @(negedge clk);
      chk($sformatf("reset%0d ctl", i), 32'(sample()), 32'd0);
      chk($sformatf("reset%0d state", i), 32'(bus.state_dbg), 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic push(input int st, input bit mr, input logic [5:0] op);
    cyc_t c;
    c.st = st; c.mr = mr; c.op = op;
    trace.push_back(c);
  endtask

  // Expected cycle trace of one instruction: fetch waits, decode, then the class-specific path
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(0, 1'b0, 6'($urandom));
    push(0, 1'b1, 6'($urandom));
    push(1, 1'($urandom), op);
    case (op)
      6'd0:  begin push(6, 1'($urandom), op); push(7, 1'($urandom), op); end
      6'd35: begin
        push(2, 1'($urandom), op);
        for (int i = 0; i < mw; i++) push(3, 1'b0, op);
        push(3, 1'b1, op);
        push(4, 1'($urandom), op);
      end
      6'd43: begin
        push(2, 1'($urandom), op);
        for (int i = 0; i < mw; i++) push(5, 1'b0, op);
        push(5, 1'b1, op);
      end
      6'd4:  push(8, 1'($urandom), op);
      6'd2:  push(9, 1'($urandom), op);
      6'd8:  if (ADDI) begin push(10, 1'($urandom), op); push(11, 1'($urandom), op); end
      default: ;
    endcase
  endtask

  initial begin
    int s, sn, nd, ni, nr, nw;
    logic [5:0] op;
    cyc_t c;

    vecs[0] = '{6'b000000, 4, 32'h0000_7610, 1, 0, 1, 0};
    vecs[1] = '{6'b100011, 7, 32'h0433_3210, 1, 0, 1, 0};
    vecs[2] = '{6'b100011, 5, 32'h0004_3210, 1, 0, 1, 0};
    vecs[3] = '{6'b101011, 4, 32'h0000_5210, 1, 0, 0, 1};
    vecs[4] = '{6'b101011, 5, 32'h0005_5210, 1, 0, 0, 2};
    vecs[5] = '{6'b000100, 3, 32'h0000_0810, 1, 0, 0, 0};
    vecs[6] = '{6'b000010, 3, 32'h0000_0910, 1, 0, 0, 0};
    vecs[7] = '{6'b000000, 6, 32'h0076_1000, 1, 0, 1, 0};
    vecs[8] = '{6'b111111, 2, 32'h0000_0010, 0, 1, 0, 0};
    if (ADDI) vecs[9] = '{6'b001000, 4, 32'h0000_BA10, 1, 0, 1, 0};
    else      vecs[9] = '{6'b001000, 2, 32'h0000_0010, 0, 1, 0, 0};

    rst = 1'b1; bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    reset_cycles(3);
    run_cycle(0, 1'b0, 6'd0, "post-reset");

    // Vector table: mem_ready is held low exactly while the next expected state repeats
    for (int v = 0; v < 10; v++) begin
      nd = 0; ni = 0; nr = 0; nw = 0;
      for (int i = 0; i < vecs[v].len; i++) begin
        s  = int'(vecs[v].seq[4*i +: 4]);
        sn = int'(vecs[v].seq[4*(i+1) +: 4]);
        bus.opcode    = vecs[v].op;
        bus.mem_ready = (s != sn);
        bus.zero      = 1'($urandom);
        @(negedge clk);
        chk($sformatf("vec%0d cyc%0d state", v, i), 32'(bus.state_dbg), 32'(s));
        chk($sformatf("vec%0d cyc%0d rd&wr", v, i), 32'(bus.mem_read & bus.mem_write), 32'd0);
        nd += int'(bus.instr_done); ni += int'(bus.illegal_op);
        nr += int'(bus.reg_write);  nw += int'(bus.mem_write);
        @(posedge clk); #1;
      end
      chk($sformatf("vec%0d done count", v), 32'(nd), 32'(vecs[v].n_done));
      chk($sformatf("vec%0d illegal count", v), 32'(ni), 32'(vecs[v].n_ill));
      chk($sformatf("vec%0d reg_write count", v), 32'(nr), 32'(vecs[v].n_rw));
      chk($sformatf("vec%0d mem_write count", v), 32'(nw), 32'(vecs[v].n_wr));
    end

    // Reset while LW waits in MEM_RD, with mem_ready high so a missed reset would write back
    run_cycle(0, 1'b1, 6'd35, "lw-rst");
    run_cycle(1, 1'b0, 6'd35, "lw-rst");
    run_cycle(2, 1'b0, 6'd35, "lw-rst");
    run_cycle(3, 1'b0, 6'd35, "lw-rst");
    run_cycle(3, 1'b0, 6'd35, "lw-rst");
    reset_cycles(3);
    run_cycle(0, 1'b0, 6'd35, "lw-rst release");

    // Reset during SW memory wait
    run_cycle(0, 1'b1, 6'd43, "sw-rst");
    run_cycle(1, 1'b1, 6'd43, "sw-rst");
    run_cycle(2, 1'b1, 6'd43, "sw-rst");
    run_cycle(5, 1'b0, 6'd43, "sw-rst");
    reset_cycles(1);
    run_cycle(0, 1'b0, 6'd43, "sw-rst release");

    // Random instruction stream with random fetch and memory wait states
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'd0;
        1: op = 6'd35;
        2: op = 6'd43;
        3: op = 6'd4;
        4: op = 6'd2;
        5: op = 6'd8;
        default: op = 6'($urandom);
      endcase
      build(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      while (trace.size() > 0) begin
        c = trace.pop_front();
        run_cycle(c.st, c.mr, c.op, $sformatf("rand%0d op%0h", n, op));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
